// File: rtl/sad_pkg.sv
// Shared helpers for the SAD accumulator: width derivations, defaults and
// pixel packing.
package sad_pkg;

    localparam int NPIX_DEF      = 8;
    localparam int PIX_W_DEF     = 8;
    localparam int MAX_BEATS_DEF = 16;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Block SAD width: one pixel difference grown by the number of terms.
    function automatic int sad_width(input int npix, input int pix_w, input int max_beats);
        return pix_w + clog2(npix * max_beats);
    endfunction

    // Width of the compressor tree sum/carry outputs for one beat.
    function automatic int tree_width(input int npix, input int pix_w);
        return pix_w + clog2(npix);
    endfunction

    localparam int TREE_W_DEF = tree_width(NPIX_DEF, PIX_W_DEF);

    // Bit offset of pixel k inside a packed beat.
    function automatic int pix_lsb(input int k, input int pix_w);
        return k * pix_w;
    endfunction

endpackage

// File: rtl/sad_accum_pipe_if.sv
// Beat-in / result-out handshake bundle of the SAD accumulator.
interface sad_accum_pipe_if
    import sad_pkg::*;
#(
    parameter int NPIX      = NPIX_DEF,
    parameter int PIX_W     = PIX_W_DEF,
    parameter int MAX_BEATS = MAX_BEATS_DEF
) ();

    localparam int SAD_W = sad_width(NPIX, PIX_W, MAX_BEATS);

    logic                    in_valid;
    logic                    in_ready;
    logic [NPIX*PIX_W-1:0]   in_cur;
    logic [NPIX*PIX_W-1:0]   in_ref;
    logic                    in_last;
    logic                    sad_valid;
    logic                    sad_ready;
    logic [SAD_W-1:0]        sad_out;
    logic                    sad_ovf;

    // Pixel fetch / cost comparator side.
    modport master (
        output in_valid, in_cur, in_ref, in_last, sad_ready,
        input  in_ready, sad_valid, sad_out, sad_ovf
    );

    // The accumulator itself.
    modport slave (
        input  in_valid, in_cur, in_ref, in_last, sad_ready,
        output in_ready, sad_valid, sad_out, sad_ovf
    );

endinterface

// File: rtl/sad_csa_tree.sv
// Combinational compressor tree: NPIX unsigned PIX_W-bit values reduced to a
// sum/carry pair using 4:2 cells where four operands remain, 3:2 otherwise.
// Carries are stored already shifted into the next column.
module sad_csa_tree
    import sad_pkg::*;
#(
    parameter int NPIX  = NPIX_DEF,
    parameter int PIX_W = PIX_W_DEF,
    localparam int TW   = tree_width(NPIX, PIX_W)
) (
    input  logic [NPIX*PIX_W-1:0] d,
    output logic [TW-1:0]         sum,
    output logic [TW-1:0]         carry
);

    localparam int IW = clog2(NPIX);

    typedef struct packed {
        logic [TW-1:0] s;
        logic [TW-1:0] c;
    } cs_t;

    // 3:2 cell: per-column full adders, carry moved up one column.
    function automatic cs_t csa32(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                  input logic [TW-1:0] c);
        cs_t           r;
        logic [TW-1:0] maj;
        maj = (a & b) | (a & c) | (b & c);
        r.s = a ^ b ^ c;
        r.c = {maj[TW-2:0], 1'b0};
        return r;
    endfunction

    // 4:2 cell: two chained 3:2 cells.
    function automatic cs_t csa42(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                  input logic [TW-1:0] c, input logic [TW-1:0] e);
        cs_t t;
        t = csa32(a, b, c);
        return csa32(t.s, t.c, e);
    endfunction

    logic [TW-1:0] ops [NPIX];
    logic [TW-1:0] nxt [NPIX];
    cs_t           p;
    int            n;
    int            m;
    int            i;

    // Repeated levels of compression until only two operands remain.
    always_comb begin
        p = '0;
        for (int k = 0; k < NPIX; k++) begin
            ops[IW'(k)] = TW'(d[pix_lsb(k, PIX_W) +: PIX_W]);
            nxt[IW'(k)] = '0;
        end
        n = NPIX;
        m = 0;
        i = 0;
        for (int lvl = 0; lvl < NPIX; lvl++) begin
            if (n > 2) begin
                m = 0;
                i = 0;
                for (int g = 0; g < NPIX; g++) begin
                    if (i + 4 <= n) begin
                        p = csa42(ops[IW'(i)], ops[IW'(i + 1)], ops[IW'(i + 2)], ops[IW'(i + 3)]);
                        nxt[IW'(m)]     = p.s;
                        nxt[IW'(m + 1)] = p.c;
                        m = m + 2;
                        i = i + 4;
                    end else if (i + 3 <= n) begin
                        p = csa32(ops[IW'(i)], ops[IW'(i + 1)], ops[IW'(i + 2)]);
                        nxt[IW'(m)]     = p.s;
                        nxt[IW'(m + 1)] = p.c;
                        m = m + 2;
                        i = i + 3;
                    end else if (i < n) begin
                        nxt[IW'(m)] = ops[IW'(i)];
                        m = m + 1;
                        i = i + 1;
                    end
                end
                for (int k = 0; k < NPIX; k++) begin
                    ops[IW'(k)] = (k < m) ? nxt[IW'(k)] : '0;
                end
                n = m;
            end
        end
        sum   = ops[0];
        carry = ops[1];
    end

endmodule

// File: rtl/sad_accum_pipe.sv
// Pipelined sum-of-absolute-differences engine. Beats of NPIX pixel pairs flow
// through absdiff, compressor tree and carry-propagate stages, then are
// accumulated over a block closed by in_last. One global advance enable
// freezes every stage while a finished result waits for the consumer.
module sad_accum_pipe
    import sad_pkg::*;
#(
    parameter int NPIX      = NPIX_DEF,
    parameter int PIX_W     = PIX_W_DEF,
    parameter int MAX_BEATS = MAX_BEATS_DEF
) (
    input logic           clk,
    input logic           rst_n,
    sad_accum_pipe_if.slave bus
);

    localparam int SAD_W = sad_width(NPIX, PIX_W, MAX_BEATS);
    localparam int TW    = tree_width(NPIX, PIX_W);
    localparam int BC_W  = clog2(MAX_BEATS + 2);
    localparam logic [BC_W-1:0] BC_MAX = BC_W'(MAX_BEATS);
    localparam logic [BC_W-1:0] BC_SAT = BC_W'(MAX_BEATS + 1);

    // Unsigned |a - b| formed on PIX_W+1 bits, returned on PIX_W bits.
    function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                  input logic [PIX_W-1:0] b);
        logic [PIX_W:0] ax;
        logic [PIX_W:0] bx;
        logic [PIX_W:0] dx;
        ax = {1'b0, a};
        bx = {1'b0, b};
        dx = (ax >= bx) ? (ax - bx) : (bx - ax);
        return dx[PIX_W-1:0];
    endfunction

    logic                  adv;
    logic [NPIX*PIX_W-1:0] absd;

    logic                  s1_valid, s1_last;
    logic [NPIX*PIX_W-1:0] s1_d;
    logic [TW-1:0]         tree_s, tree_c;
    logic                  s2_valid, s2_last;
    logic [TW-1:0]         s2_s, s2_c;
    logic                  s3_valid, s3_last;
    logic [TW-1:0]         s3_sum;

    logic [SAD_W-1:0]      acc;
    logic [BC_W-1:0]       bcnt;
    logic                  first;
    logic                  ovf_sticky;

    logic [SAD_W-1:0]      beat_ext;
    logic [BC_W-1:0]       cnt_next;
    logic                  ovf_now;
    logic [SAD_W-1:0]      acc_next;
    logic                  acc_step;
    logic                  load_res;

    logic                  sad_valid_q;
    logic [SAD_W-1:0]      sad_out_q;
    logic                  sad_ovf_q;

    // Whole pipe freezes only while a result sits unconsumed.
    assign adv           = !(sad_valid_q && !bus.sad_ready);
    assign bus.in_ready  = adv;
    assign bus.sad_valid = sad_valid_q;
    assign bus.sad_out   = sad_out_q;
    assign bus.sad_ovf   = sad_ovf_q;

    // Per-pixel absolute difference of the presented beat.
    // NOTE: outputs get a value on every path through the block, so no latch is inferred.
    always_comb begin
        absd = '0;
        for (int k = 0; k < NPIX; k++) begin
            absd[pix_lsb(k, PIX_W) +: PIX_W] =
                abs_diff(bus.in_cur[pix_lsb(k, PIX_W) +: PIX_W],
                         bus.in_ref[pix_lsb(k, PIX_W) +: PIX_W]);
        end
    end

    // S1: capture absolute differences of an accepted beat.
    // NOTE: non-blocking assignments so each stage samples its pre-edge inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_d     <= '0;
        end else if (adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_last <= bus.in_last;
                s1_d    <= absd;
            end
        end
    end

    sad_csa_tree #(
        .NPIX  (NPIX),
        .PIX_W (PIX_W)
    ) u_tree (
        .d     (s1_d),
        .sum   (tree_s),
        .carry (tree_c)
    );

    // S2: capture the redundant sum/carry pair from the tree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_s     <= '0;
            s2_c     <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_last <= s1_last;
                s2_s    <= tree_s;
                s2_c    <= tree_c;
            end
        end
    end

    // S3: resolve the pair into a binary beat sum before accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid <= 1'b0;
            s3_last  <= 1'b0;
            s3_sum   <= '0;
        end else if (adv) begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_last <= s2_last;
                s3_sum  <= s2_s + s2_c;
            end
        end
    end

    // Next accumulator value: load on a block's first beat, saturate once the
    // block runs past MAX_BEATS beats.
    always_comb begin
        beat_ext = SAD_W'(s3_sum);
        cnt_next = (bcnt == BC_SAT) ? BC_SAT : (bcnt + BC_W'(1));
        ovf_now  = ovf_sticky || (cnt_next > BC_MAX);
        acc_next = first ? beat_ext : (acc + beat_ext);
        if (ovf_now) begin
            acc_next = '1;
        end
        acc_step = adv && s3_valid;
        load_res = acc_step && s3_last;
    end

    // Block accumulator, beat counter and block-start flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            bcnt       <= '0;
            first      <= 1'b1;
            ovf_sticky <= 1'b0;
        end else if (acc_step) begin
            acc <= acc_next;
            if (s3_last) begin
                bcnt       <= '0;
                first      <= 1'b1;
                ovf_sticky <= 1'b0;
            end else begin
                bcnt       <= cnt_next;
                first      <= 1'b0;
                ovf_sticky <= ovf_now;
            end
        end
    end

    // Result register: loads a finished block, otherwise empties on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sad_valid_q <= 1'b0;
            sad_out_q   <= '0;
            sad_ovf_q   <= 1'b0;
        end else if (load_res) begin
            sad_valid_q <= 1'b1;
            sad_out_q   <= acc_next;
            sad_ovf_q   <= ovf_now;
        end else if (bus.sad_ready) begin
            sad_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sad_accum_pipe.sv
// Self-checking bench for sad_accum_pipe: directed scenarios plus random
// blocks, scored against a plain-arithmetic model of block SAD.
module tb_sad_accum_pipe;
    import sad_pkg::*;

    localparam int NPIX      = 8;
    localparam int PIX_W     = 8;
    localparam int MAX_BEATS = 16;
    localparam int W         = NPIX * PIX_W;
    localparam int SAD_W     = PIX_W + $clog2(NPIX * MAX_BEATS);
    localparam int ALL_ONES  = (1 << SAD_W) - 1;

    typedef struct {
        int val;
        int ovf;
    } exp_t;

    logic   clk   = 1'b0;
    logic   rst_n = 1'b1;
    int     errors = 0;
    int     checks = 0;
    int     ready_ctl = 1;
    exp_t   expq[$];
    int     blk_sum = 0;
    int     blk_beats = 0;

    logic [W-1:0] c_v, r_v;
    logic         prev_rdy, found;
    int           len;
    int           v;

    sad_accum_pipe_if #(.NPIX(NPIX), .PIX_W(PIX_W), .MAX_BEATS(MAX_BEATS)) bus ();

    sad_accum_pipe #(.NPIX(NPIX), .PIX_W(PIX_W), .MAX_BEATS(MAX_BEATS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int beat_sad(input logic [W-1:0] c, input logic [W-1:0] r);
        int s;
        int a;
        int b;
        s = 0;
        for (int k = 0; k < NPIX; k++) begin
            a = int'(c[k*PIX_W +: PIX_W]);
            b = int'(r[k*PIX_W +: PIX_W]);
            s += (a > b) ? (a - b) : (b - a);
        end
        return s;
    endfunction

    function automatic logic [W-1:0] fill(input logic [7:0] p);
        return {NPIX{p}};
    endfunction

    // Present one beat, hold it until accepted, then fold it into the model.
    task automatic send_beat(input logic [W-1:0] c, input logic [W-1:0] r, input logic last);
        int   waited;
        logic acc_ok;
        waited = 0;
        acc_ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_cur   = c;
        bus.in_ref   = r;
        bus.in_last  = last;
        while (!acc_ok && waited < 200) begin
            @(negedge clk);
            acc_ok = bus.in_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        check("beat_accept", acc_ok, 1);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        blk_sum   += beat_sad(c, r);
        blk_beats += 1;
        if (last) begin
            if (blk_beats > MAX_BEATS) expq.push_back('{ALL_ONES, 1});
            else                       expq.push_back('{blk_sum, 0});
            blk_sum   = 0;
            blk_beats = 0;
        end
    endtask

    // Wait for the next result and compare it to a directed value.
    task automatic expect_now(input string tag, input int val, input int ovf);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.sad_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, bus.sad_valid, 1);
        check({tag, "_sad"}, bus.sad_out, val);
        check({tag, "_ovf"}, bus.sad_ovf, ovf);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((expq.size() != 0 || bus.sad_valid) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_pending", expq.size(), 0);
    endtask

    // Consumer side: sad_ready pattern selected by ready_ctl (0 low, 1 high, 2 random).
    initial begin
        bus.sad_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (ready_ctl == 2) bus.sad_ready = ($urandom_range(0, 3) != 0);
            else                bus.sad_ready = (ready_ctl == 1);
        end
    end

    // Scoreboard: every handshaken result must match the oldest expected block.
    always @(negedge clk) begin
        if (rst_n && bus.sad_valid && bus.sad_ready) begin
            check("result_expected", (expq.size() > 0), 1);
            if (expq.size() > 0) begin
                check("sb_sad", bus.sad_out, expq[0].val);
                check("sb_ovf", bus.sad_ovf, expq[0].ovf);
                void'(expq.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_cur   = '0;
        bus.in_ref   = '0;

        // Reset values, applied asynchronously before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_sad_valid", bus.sad_valid, 0);
        check("rst_sad_out", bus.sad_out, 0);
        check("rst_sad_ovf", bus.sad_ovf, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full-scale single beat and its three-cycle latency.
        send_beat(fill(8'hFF), fill(8'h00), 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("lat_early_valid", bus.sad_valid, 0);
        end
        @(negedge clk);
        check("lat_t3_valid", bus.sad_valid, 1);
        check("t1_sad", bus.sad_out, 2040);
        check("t1_ovf", bus.sad_ovf, 0);
        @(posedge clk);
        #1;
        drain();

        // Four-beat block with cur = ref + 3, then a fresh block.
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < NPIX; k++) begin
                v = $urandom_range(0, 252);
                r_v[k*PIX_W +: PIX_W] = PIX_W'(v);
                c_v[k*PIX_W +: PIX_W] = PIX_W'(v + 3);
            end
            send_beat(c_v, r_v, b == 3);
        end
        expect_now("t2_block", 96, 0);
        send_beat(fill(8'h41), fill(8'h40), 1'b1);
        expect_now("t2_next", 8, 0);

        // cur below ref.
        send_beat(fill(8'h10), fill(8'h90), 1'b1);
        expect_now("t3_neg", 1024, 0);

        // Overflow by one beat, then a normal block.
        for (int b = 0; b < MAX_BEATS + 1; b++) begin
            send_beat(fill(8'hFF), fill(8'h00), b == MAX_BEATS);
        end
        expect_now("t4_ovf", ALL_ONES, 1);
        send_beat(fill(8'h20), fill(8'h30), 1'b1);
        expect_now("t4_after", 128, 0);
        drain();

        // Three single-beat blocks into a stalled consumer.
        ready_ctl = 0;
        for (int b = 0; b < 3; b++) begin
            c_v = {$urandom, $urandom};
            r_v = {$urandom, $urandom};
            send_beat(c_v, r_v, 1'b1);
        end
        prev_rdy = 1'b0;
        found    = 1'b0;
        for (int n = 0; n < 10 && !found; n++) begin
            @(negedge clk);
            if (bus.sad_valid) found = 1'b1;
            else               prev_rdy = bus.in_ready;
        end
        check("stall_valid_rise", bus.sad_valid, 1);
        check("stall_ready_same_cycle", bus.in_ready, 0);
        check("stall_ready_before", prev_rdy, 1);
        bus.in_valid = 1'b1;
        bus.in_last  = 1'b1;
        bus.in_cur   = {$urandom, $urandom};
        bus.in_ref   = {$urandom, $urandom};
        for (int n = 0; n < 5; n++) begin
            check("stall_hold_valid", bus.sad_valid, 1);
            check("stall_hold_ready", bus.in_ready, 0);
            check("stall_hold_sad", bus.sad_out, expq[0].val);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        ready_ctl = 1;
        drain();

        // Reset in the middle of a four-beat block.
        for (int b = 0; b < 2; b++) begin
            send_beat({$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
        end
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", bus.in_ready, 1);
        check("mid_rst_sad_valid", bus.sad_valid, 0);
        check("mid_rst_sad_out", bus.sad_out, 0);
        check("mid_rst_sad_ovf", bus.sad_ovf, 0);
        blk_sum   = 0;
        blk_beats = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        c_v = {$urandom, $urandom};
        r_v = {$urandom, $urandom};
        send_beat(c_v, r_v, 1'b1);
        expect_now("post_rst", beat_sad(c_v, r_v), 0);
        drain();

        // Random blocks with bubbles and random back-pressure.
        ready_ctl = 2;
        for (int b = 0; b < 25; b++) begin
            len = (b == 12) ? MAX_BEATS + 2 : $urandom_range(1, 4);
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 2) == 0) begin
                    repeat ($urandom_range(1, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                send_beat({$urandom, $urandom}, {$urandom, $urandom}, j == len - 1);
            end
        end
        ready_ctl = 1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sad_accum_pipe.md
# sad_accum_pipe

Parametrised, pipelined sum-of-absolute-difference engine. Each accepted beat carries NPIX current/reference pixel pairs. Per-pixel absolute differences are reduced to a carry-save pair by a column-wise compressor tree, then summed and accumulated over a variable-length block delimited by `in_last`. It sits between the pixel-fetch stage and the motion-estimation cost comparator, and supersedes the fixed 8-input single-column compressor with a registered, back-pressurable, multi-beat datapath.

## Interface
- NPIX, 8: pixel pairs per beat; legal values 2..16.
- PIX_W, 8: pixel width in bits.
- MAX_BEATS, 16: maximum beats per block; sizes the accumulator.
- SAD_W, PIX_W+clog2(NPIX*MAX_BEATS): result width; derived, not to be overridden.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  beat present.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_cur  in  NPIX*PIX_W  current pixels; pixel k occupies bits [k*PIX_W +: PIX_W].
- in_ref  in  NPIX*PIX_W  reference pixels, same packing.
- in_last  in  1  final beat of a block.
- sad_valid  out  1  result held.
- sad_ready  in  1  result consumed when sad_valid && sad_ready.
- sad_out  out  SAD_W  block SAD.
- sad_ovf  out  1  block exceeded MAX_BEATS beats; sad_out is saturated.

## Operation
- Global advance enable `adv = !(sad_valid && !sad_ready)`. in_ready = adv. Every pipeline register holds its value when adv is 0.
- S1, absdiff: per pixel, `d_k = |cur_k - ref_k|`, computed unsigned on PIX_W+1 bits and truncated to PIX_W bits. Registered together with valid and last.
- S2, reduce: NPIX values of PIX_W bits are reduced to a sum/carry pair of PIX_W+clog2(NPIX) bits by a tree of 3:2 and 4:2 cells, with column carries passed to the next column. Registered together with valid and last.
- S3, accumulate: CPA of sum and carry, added to the accumulator `acc`.
  - First beat of a block (`first` flag set): acc loads the beat sum instead of adding to it.
  - A beat counter `bcnt` increments on each valid S3 beat. On reaching beat MAX_BEATS+1, sad_ovf is set sticky and acc saturates to all-ones.
  - On a valid S3 beat with last set: acc + beat sum (or the saturated value) is loaded into sad_out and sad_valid is set. sad_ovf is captured with it. `first` is set and bcnt is cleared.
- Output register: sad_valid clears on handshake unless a new result loads in the same cycle. Because adv is gated, a new result can only arrive when the register is empty or being drained.
- Bubbles (in_valid low) propagate as invalid stages and do not touch acc.
- A single-beat block (in_last on its first beat) yields that beat's SAD.

## Timing
- Reset values: in_ready 1, sad_valid 0, sad_out 0, sad_ovf 0. Internally: stage valids 0, acc 0, bcnt 0, first 1.
- Latency: an in_last beat accepted at edge t gives sad_valid high after edge t+3, provided there is no stall.
- Throughput: one beat per cycle. Block results can come back-to-back, one per cycle, if every block is a single beat and sad_ready is held high.
- Stall: while sad_valid && !sad_ready, in_ready is low in the same cycle (combinational) and no stage advances.
- Reset asserted mid-block aborts the block. All stages invalidate immediately and no partial result is emitted.
- Inputs are sampled only on an accepted beat. Values presented while in_ready is low are ignored.

## Structure
- Package `sad_pkg`:
  - clog2 function.
  - SAD_W derivation function.
  - localparam for the tree output width.
  - Packing helper (pixel index to bit offset).
- Sub-module `sad_csa_tree`: parametrised in NPIX and PIX_W, purely combinational, built from the existing 3:2 and 4:2 compressor cells. The parent instantiates it once between S1 and S2.

## Test plan
- NPIX=8, PIX_W=8, one beat: cur all 0xFF, ref all 0x00, in_last=1 -> sad_out=2040, sad_ovf=0, sad_valid 3 cycles after acceptance.
- Four-beat block with cur=ref+3 for all pixels, then in_last -> sad_out=96. The next block starts from 0 with no carry-over.
- cur < ref: cur=0x10, ref=0x90 on every pixel, one beat -> sad_out=1024, confirming the unsigned absolute value.
- MAX_BEATS=16, 17 beats of full-scale difference -> sad_ovf=1, sad_out all-ones. The following normal block -> sad_ovf=0 and the correct value.
- sad_ready held low for 5 cycles while three single-beat blocks stream in:
  - in_ready drops in the same cycle sad_valid rises.
  - No beat is lost or duplicated.
  - The three results appear in order once sad_ready is released.
- rst_n pulsed low after beat 2 of a 4-beat block -> outputs take their reset values asynchronously. A subsequent single-beat block gives only its own SAD.
